// File: rtl/tree_sum_accumulator.sv
// tree_sum_accumulator: accumulates cfg_len signed tree sums per group into a 2-deep result FIFO
module tree_sum_accumulator #(
  parameter int WIDTH = 13,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_MAX = 256,
  parameter int SAT = 1,
  localparam int LW = $clog2(LEN_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LW-1:0]        cfg_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 busy
);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state;
  logic [LW-1:0] cnt, len_q, eff_len;
  logic [ACC_WIDTH-1:0] acc, res;
  logic [ACC_WIDTH:0] nxt;
  logic [ACC_WIDTH:0] mem [2];
  logic ovf, ovf_now, accept, last, push, pop, rd_ptr, wr_ptr;
  logic [1:0] count;
  assign in_ready = !rst && count != 2'd2;
  assign accept = in_valid && in_ready;
  assign eff_len = cfg_len == '0 ? LW'(1) : cfg_len;
  // one guard bit above the accumulator exposes signed overflow
  assign nxt = (state == IDLE ? '0 : {acc[ACC_WIDTH-1], acc})
             + {{(ACC_WIDTH + 1 - WIDTH){in_sum[WIDTH-1]}}, in_sum};
  assign ovf_now = nxt[ACC_WIDTH] != nxt[ACC_WIDTH-1];
  assign res = (SAT != 0 && ovf_now) ? {nxt[ACC_WIDTH], {(ACC_WIDTH - 1){!nxt[ACC_WIDTH]}}}
                                     : nxt[ACC_WIDTH-1:0];
  assign last = state == IDLE ? eff_len == LW'(1) : cnt == len_q - 1'b1;
  assign push = accept && last;
  assign pop = out_valid && out_ready;
  assign out_valid = count != 2'd0;
  assign out_sum = mem[rd_ptr][ACC_WIDTH-1:0];
  assign out_ovf = mem[rd_ptr][ACC_WIDTH];
  assign busy = state == ACCUM;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      len_q <= '0;
      ovf <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (accept) begin
        if (state == IDLE) len_q <= eff_len;
        if (last) begin
          state <= IDLE;
          cnt <= '0;
          ovf <= 1'b0;
        end else begin
          state <= ACCUM;
          acc <= res;
          cnt <= cnt + 1'b1;
          ovf <= ovf | ovf_now;
        end
      end
      if (push) begin
        mem[wr_ptr] <= {ovf | ovf_now, res};
        wr_ptr <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_tree_sum_accumulator.sv
// tb_tree_sum_accumulator: saturating and wrapping instances driven in lockstep against a group-level model
module tb_tree_sum_accumulator;
  localparam int HI = 8191, LO = -8192, M = 16384;
  logic clk = 1'b0, rst;
  logic [4:0] cfg_len;
  logic in_valid, out_ready;
  logic [12:0] in_sum;
  logic in_ready_s, out_valid_s, out_ovf_s, busy_s;
  logic in_ready_w, out_valid_w, out_ovf_w, busy_w;
  logic [13:0] out_sum_s, out_sum_w;
  int n_checks = 0, n_fail = 0;
  int qs_sum[$], qw_sum[$];
  bit qs_ovf[$], qw_ovf[$];
  int g_cnt = 0, g_len = 0, run_s = 0, run_w = 0;
  bit ov_s = 0, ov_w = 0, acc_flag = 0;

  always #5 clk = ~clk;

  tree_sum_accumulator #(.WIDTH(13), .ACC_WIDTH(14), .LEN_MAX(16), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_sum(in_sum), .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
    .out_ovf(out_ovf_s), .busy(busy_s));

  tree_sum_accumulator #(.WIDTH(13), .ACC_WIDTH(14), .LEN_MAX(16), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_sum(in_sum), .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w),
    .out_ovf(out_ovf_w), .busy(busy_w));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input int x, input int len);
    int t;
    if (g_cnt == 0) begin
      g_len = len == 0 ? 1 : len;
      run_s = 0; run_w = 0; ov_s = 0; ov_w = 0;
    end
    t = run_s + x;
    if (t > HI || t < LO) ov_s = 1;
    run_s = t > HI ? HI : t < LO ? LO : t;
    t = run_w + x;
    if (t > HI || t < LO) ov_w = 1;
    run_w = t > HI ? t - M : t < LO ? t + M : t;
    g_cnt++;
    if (g_cnt == g_len) begin
      qs_sum.push_back(run_s); qs_ovf.push_back(ov_s);
      qw_sum.push_back(run_w); qw_ovf.push_back(ov_w);
      g_cnt = 0;
    end
  endtask

  task automatic model_reset();
    qs_sum.delete(); qs_ovf.delete(); qw_sum.delete(); qw_ovf.delete();
    g_cnt = 0;
  endtask

  task automatic step(input bit v, input int s, input int len, input bit ordy);
    bit rdy;
    @(negedge clk);
    in_valid = v; in_sum = 13'(s); cfg_len = 5'(len); out_ready = ordy;
    #1;
    rdy = qs_sum.size() != 2;
    check("in_ready_s", in_ready_s, rdy);
    check("in_ready_w", in_ready_w, rdy);
    check("out_valid_s", out_valid_s, qs_sum.size() != 0);
    check("out_valid_w", out_valid_w, qw_sum.size() != 0);
    check("busy_s", busy_s, g_cnt != 0);
    check("busy_w", busy_w, g_cnt != 0);
    if (ordy && qs_sum.size() != 0) begin
      check("out_sum_s", int'($signed(out_sum_s)), qs_sum.pop_front());
      check("out_ovf_s", out_ovf_s, qs_ovf.pop_front());
      check("out_sum_w", int'($signed(out_sum_w)), qw_sum.pop_front());
      check("out_ovf_w", out_ovf_w, qw_ovf.pop_front());
    end
    acc_flag = v && rdy;
    if (acc_flag) model(s, len);
  endtask

  task automatic feed(input int s, input int len, input bit ordy);
    int n = 0;
    do begin
      step(1'b1, s, len, ordy);
      n++;
    end while (!acc_flag && n < 50);
    if (!acc_flag) check("feed_timeout", 0, 1);
  endtask

  function automatic int rand_sum();
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1) != 0 ? 4095 : -4096;
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    in_valid = 0; in_sum = '0; cfg_len = '0; out_ready = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready_s, 0);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_out_sum", int'(out_sum_s), 0);
    check("rst_busy", busy_s, 0);
    rst = 1'b0;
    // four-term group, result visible one cycle after the last accept
    feed(100, 4, 1); feed(-3, 4, 1); feed(7, 4, 1); feed(4095, 4, 1);
    step(0, 0, 4, 1);
    check("t1_valid", out_valid_s, 1);
    check("t1_sum", int'($signed(out_sum_s)), 4199);
    check("t1_ovf", out_ovf_s, 0);
    // single-term groups at the input extremes
    feed(-4096, 1, 1); feed(4095, 1, 1);
    check("t2_first", int'($signed(out_sum_s)), -4096);
    step(0, 0, 1, 1);
    check("t2_second", int'($signed(out_sum_s)), 4095);
    // saturation versus wrap, sticky flag cleared for the next group
    feed(4095, 3, 1); feed(4095, 3, 1); feed(4095, 3, 1);
    step(0, 0, 3, 1);
    check("t3_sum_s", int'($signed(out_sum_s)), 8191);
    check("t3_ovf_s", out_ovf_s, 1);
    check("t3_sum_w", int'($signed(out_sum_w)), -4099);
    check("t3_ovf_w", out_ovf_w, 1);
    feed(1, 2, 1); feed(1, 2, 1);
    step(0, 0, 2, 1);
    check("t3_next_sum", int'($signed(out_sum_s)), 2);
    check("t3_next_ovf", out_ovf_s, 0);
    // FIFO full backpressure
    for (int i = 1; i <= 4; i++) feed(i, 2, 0);
    step(1, 5, 2, 0);
    check("t4_stall", in_ready_s, 0);
    feed(5, 2, 1); feed(6, 2, 1);
    repeat (4) step(0, 0, 2, 1);
    check("t4_drained", out_valid_s, 0);
    // reset mid-group with an unread result pending
    feed(77, 1, 0);
    feed(1, 5, 0); feed(2, 5, 0); feed(3, 5, 0);
    rst = 1'b1;
    #1;
    check("t5_out_valid", out_valid_s, 0);
    check("t5_out_sum", int'(out_sum_s), 0);
    check("t5_out_ovf", out_ovf_s, 0);
    check("t5_busy", busy_s, 0);
    check("t5_in_ready", in_ready_s, 0);
    model_reset();
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    feed(10, 2, 1); feed(20, 2, 1);
    step(0, 0, 2, 1);
    check("t5_sum", int'($signed(out_sum_s)), 30);
    // zero length means one, and length is latched at the first term
    feed(-1, 0, 1);
    step(0, 0, 0, 1);
    check("t6_sum", int'(out_sum_s), 16383);
    feed(5, 3, 1); feed(6, 7, 1); feed(7, 7, 1);
    step(0, 0, 7, 1);
    check("t6_len_valid", out_valid_s, 1);
    check("t6_len_sum", int'($signed(out_sum_s)), 18);
    // random traffic with random backpressure and mid-group cfg_len churn
    repeat (3000) step($urandom_range(0, 3) != 0, rand_sum(), $urandom_range(0, 6), $urandom_range(0, 9) < 7);
    while (g_cnt != 0) feed(rand_sum(), 1, 1);
    repeat (4) step(0, 0, 1, 1);
    check("final_drained", out_valid_s, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
